// File: rtl/rvic_src_cond_if.sv
// Bundle between the interrupt source conditioner and its neighbours: the raw
// lines and per-source configuration/handshake in, conditioned requests and
// lost-edge flags out.
interface rvic_src_cond_if #(
  parameter int unsigned NUM_SRC = 32
);
  logic [NUM_SRC-1:0] irq_raw_i;
  logic [NUM_SRC-1:0] mode_i;
  logic [NUM_SRC-1:0] pol_i;
  logic [NUM_SRC-1:0] consume_i;
  logic [NUM_SRC-1:0] ovf_clr_i;
  logic [NUM_SRC-1:0] src_o;
  logic [NUM_SRC-1:0] ovf_o;

  modport master (
    output irq_raw_i, mode_i, pol_i, consume_i, ovf_clr_i,
    input  src_o, ovf_o
  );

  modport slave (
    input  irq_raw_i, mode_i, pol_i, consume_i, ovf_clr_i,
    output src_o, ovf_o
  );
endinterface

// File: rtl/rvic_src_cond.sv
// Interrupt source conditioner feeding the controller core's src_i input.
// Synchronises raw lines, applies polarity, and either passes the level
// through or holds rising edges until the controller consumes them.
// Define RVIC_SRC_FILTER_EN to add a per-source glitch filter of
// FILTER_CYCLES stable cycles after the synchroniser.
module rvic_src_cond #(
  parameter int unsigned NUM_SRC       = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rvic_src_cond_if.slave  bus
);

`ifdef RVIC_SRC_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int unsigned WARM   = SYNC_STAGES + 1 + (FILT_EN ? FILTER_CYCLES : 0);
  localparam int unsigned WARM_W = $clog2(WARM + 1);

  typedef logic [NUM_SRC-1:0] vec_t;

  vec_t              sync_q [SYNC_STAGES];
  vec_t              s;
  vec_t              f;
  vec_t              a;
  vec_t              prev_q;
  vec_t              latch_q;
  vec_t              ovf_q;
  vec_t              mode_q;
  vec_t              pol_q;
  vec_t              cfg_chg;
  vec_t              rise;
  vec_t              latch_d;
  vec_t              ovf_d;
  logic [WARM_W-1:0] warm_q;
  logic              warm_done;

  // Multi-flop synchroniser for the asynchronous raw lines
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.irq_raw_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef RVIC_SRC_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILTER_CYCLES + 1);

  logic [FCNT_W-1:0] fcnt_q [NUM_SRC];
  vec_t              filt_q;

  // Glitch filter: follow s only after it has differed for FILTER_CYCLES cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= '0;
      for (int n = 0; n < int'(NUM_SRC); n++) fcnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < int'(NUM_SRC); n++) begin
        if (s[n] != filt_q[n]) begin
          if (fcnt_q[n] == FCNT_W'(FILTER_CYCLES - 1)) begin
            filt_q[n] <= s[n];
            fcnt_q[n] <= '0;
          end else begin
            fcnt_q[n] <= fcnt_q[n] + FCNT_W'(1);
          end
        end else begin
          fcnt_q[n] <= '0;
        end
      end
    end
  end

  assign f = filt_q;
`else
  assign f = s;
`endif

  // Warm-up counter: suppresses edge capture until the pipeline holds real data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_q <= '0;
    end else if (!warm_done) begin
      warm_q <= warm_q + WARM_W'(1);
    end
  end

  assign warm_done = (warm_q == WARM_W'(WARM));

  // Edge detection, pending latch and sticky overflow next-state
  always_comb begin
    a       = '0;
    cfg_chg = '0;
    rise    = '0;
    latch_d = '0;
    ovf_d   = '0;
    a       = f ^ bus.pol_i;
    cfg_chg = (bus.mode_i ^ mode_q) | (bus.pol_i ^ pol_q);
    rise    = a & ~prev_q & bus.mode_i & ~cfg_chg & {NUM_SRC{warm_done}};
    latch_d = (rise | (latch_q & ~bus.consume_i)) & bus.mode_i & ~cfg_chg;
    ovf_d   = (rise & latch_q & ~bus.consume_i) | (ovf_q & ~bus.ovf_clr_i);
  end

  // Per-source state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= '0;
      latch_q <= '0;
      ovf_q   <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
    end else begin
      prev_q  <= a;
      latch_q <= latch_d;
      ovf_q   <= ovf_d;
      mode_q  <= bus.mode_i;
      pol_q   <= bus.pol_i;
    end
  end

  // Level sources pass straight through; edge sources present the pending latch
  assign bus.src_o = rst_ni ? ((bus.mode_i & latch_q) | (~bus.mode_i & a)) : '0;
  assign bus.ovf_o = ovf_q;

endmodule

// File: tb/tb_rvic_src_cond.sv
// Directed bench for rvic_src_cond: level/edge paths, overflow, polarity
// warm-up, config change and asynchronous reset.
module tb_rvic_src_cond;

`ifdef RVIC_SRC_FILTER_EN
  localparam int FD = 4;
`else
  localparam int FD = 0;
`endif
  localparam int PW    = (FD == 0) ? 1 : FD;
  localparam int LAT_E = 3 + FD - PW;
  localparam int WARM  = 3 + FD;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  rvic_src_cond_if #(.NUM_SRC(32)) bus ();

  rvic_src_cond #(
    .NUM_SRC      (32),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] m);
    bus.irq_raw_i = bus.irq_raw_i | m;
    tick(PW);
    bus.irq_raw_i = bus.irq_raw_i & ~m;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_ni         = 1'b0;
    bus.irq_raw_i  = '0;
    bus.mode_i     = '1;
    bus.pol_i      = '1;
    bus.consume_i  = '0;
    bus.ovf_clr_i  = '0;

    // Reset: outputs forced low even with active-low normalised value of 1
    tick(3);
    check("rst_src", bus.src_o, 32'h0);
    check("rst_ovf", bus.ovf_o, 32'h0);

    // Active-low edge sources through reset release: no spurious events
    rst_ni = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("warm_src", bus.src_o, 32'h0);
      check("warm_ovf", bus.ovf_o, 32'h0);
    end
    bus.irq_raw_i[0] = 1'b1;
    tick(3 + FD);
    check("pol_high_noev", bus.src_o, 32'h0);
    bus.irq_raw_i[0] = 1'b0;
    tick(2 + FD);
    check("pol_fall_early", bus.src_o, 32'h0);
    tick(1);
    check("pol_fall_latch", bus.src_o, 32'h1);
    bus.consume_i[0] = 1'b1;
    tick(1);
    bus.consume_i[0] = 1'b0;
    check("pol_consumed", bus.src_o, 32'h0);
    check("pol_ovf", bus.ovf_o, 32'h0);

    // Back to active-high level mode everywhere
    bus.pol_i  = '0;
    bus.mode_i = '0;
    tick(2);
    check("lvl_idle", bus.src_o, 32'h0);

    // Level mode, source 3; consume ignored
    bus.consume_i    = '1;
    bus.irq_raw_i[3] = 1'b1;
    tick(1 + FD);
    check("lvl_rise_early", bus.src_o, 32'h0);
    tick(1);
    check("lvl_rise", bus.src_o, 32'h8);
    tick(5);
    check("lvl_hold", bus.src_o, 32'h8);
    bus.irq_raw_i[3] = 1'b0;
    tick(1 + FD);
    check("lvl_fall_early", bus.src_o, 32'h8);
    tick(1);
    check("lvl_fall", bus.src_o, 32'h0);
    bus.consume_i = '0;

    // Edge mode, source 5: held until consumed
    bus.mode_i = 32'h0000_0020;
    tick(2);
    pulse(32'h0000_0020);
    tick(LAT_E - 1);
    check("edge_early", bus.src_o, 32'h0);
    tick(1);
    check("edge_latch", bus.src_o, 32'h20);
    tick(10);
    check("edge_hold", bus.src_o, 32'h20);
    bus.consume_i[5] = 1'b1;
    tick(1);
    bus.consume_i[5] = 1'b0;
    check("edge_consume", bus.src_o, 32'h0);
    check("edge_no_ovf", bus.ovf_o, 32'h0);

    // Edge mode, source 7: overflow, clear, and edge coinciding with consume
    bus.mode_i = 32'h0000_00A0;
    tick(2);
    pulse(32'h0000_0080);
    tick(LAT_E);
    check("ovf_first", bus.src_o, 32'h80);
    pulse(32'h0000_0080);
    tick(LAT_E);
    check("ovf_set", bus.ovf_o, 32'h80);
    check("ovf_src", bus.src_o, 32'h80);
    tick(3);
    check("ovf_sticky", bus.ovf_o, 32'h80);
    bus.ovf_clr_i[7] = 1'b1;
    tick(1);
    bus.ovf_clr_i[7] = 1'b0;
    check("ovf_clr", bus.ovf_o, 32'h0);
    pulse(32'h0000_0080);
    tick(LAT_E - 1);
    bus.consume_i[7] = 1'b1;
    tick(1);
    bus.consume_i[7] = 1'b0;
    check("coinc_src", bus.src_o, 32'h80);
    check("coinc_ovf", bus.ovf_o, 32'h0);
    pulse(32'h0000_0080);
    tick(LAT_E - 1);
    bus.ovf_clr_i[7] = 1'b1;
    tick(1);
    bus.ovf_clr_i[7] = 1'b0;
    check("ovf_set_wins", bus.ovf_o, 32'h80);
    bus.ovf_clr_i[7] = 1'b1;
    bus.consume_i[7] = 1'b1;
    tick(1);
    bus.ovf_clr_i[7] = 1'b0;
    bus.consume_i[7] = 1'b0;
    check("s7_clean_src", bus.src_o, 32'h0);
    check("s7_clean_ovf", bus.ovf_o, 32'h0);

`ifdef RVIC_SRC_FILTER_EN
    // Glitch filter in level mode
    bus.mode_i = '0;
    tick(2);
    bus.irq_raw_i[3] = 1'b1;
    tick(3);
    bus.irq_raw_i[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("flt_glitch", bus.src_o, 32'h0);
    end
    bus.irq_raw_i[3] = 1'b1;
    tick(5);
    check("flt_rise_early", bus.src_o, 32'h0);
    tick(1);
    bus.irq_raw_i[3] = 1'b0;
    check("flt_rise", bus.src_o, 32'h8);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("flt_high", bus.src_o, 32'h8);
    end
    tick(1);
    check("flt_fall", bus.src_o, 32'h0);
`endif

    // Sources 0 and 31 latched, mode toggle, then reset mid-run
    bus.mode_i = 32'h8000_00A1;
    tick(2);
    pulse(32'h8000_0001);
    tick(LAT_E);
    check("mr_latch", bus.src_o, 32'h8000_0001);
    pulse(32'h8000_0000);
    tick(LAT_E);
    check("mr_ovf31", bus.ovf_o, 32'h8000_0000);
    bus.mode_i[0] = 1'b0;
    tick(1);
    check("cfg_clr", bus.src_o, 32'h8000_0000);
    bus.mode_i[0] = 1'b1;
    tick(3);
    check("cfg_noev", bus.src_o, 32'h8000_0000);
    check("cfg_ovf_kept", bus.ovf_o, 32'h8000_0000);
    rst_ni = 1'b0;
    #1;
    check("mr_rst_src", bus.src_o, 32'h0);
    check("mr_rst_ovf", bus.ovf_o, 32'h0);
    tick(2);
    rst_ni = 1'b1;
    tick(WARM + 2);
    check("mr_post_src", bus.src_o, 32'h0);
    check("mr_post_ovf", bus.ovf_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvic_src_cond.md
Name: rvic_src_cond

Overview:
Interrupt source conditioner placed directly upstream of the interrupt controller core. It drives that core's 32-bit src_i input.
- Synchronises asynchronous raw interrupt lines.
- Applies per-source polarity.
- Selects per-source level or edge mode. Edge events are held until the controller consumes them, so a pulse that loses priority arbitration is not dropped.
- Reports lost edges (overflow) per source.

Parameters:
NUM_SRC, 32, number of interrupt sources; must match controller width.
SYNC_STAGES, 2, synchroniser depth (>=2).
FILTER_CYCLES, 4, glitch-filter stability length in cycles (>=1); used only when RVIC_SRC_FILTER_EN is defined.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset, asynchronous, active-low.
irq_raw_i  input  NUM_SRC  raw asynchronous interrupt lines.
mode_i  input  NUM_SRC  per source: 1 = edge mode, 0 = level mode; quasi-static.
pol_i  input  NUM_SRC  per source: 1 = active-low / falling edge, 0 = active-high / rising edge.
consume_i  input  NUM_SRC  per-source pulse from the controller: event captured into pending.
ovf_clr_i  input  NUM_SRC  per-source pulse: clear overflow flag.
src_o  output  NUM_SRC  conditioned request to the controller.
ovf_o  output  NUM_SRC  sticky lost-edge flag.

Behaviour:
Reset values: all synchroniser flops, filter state, prev, latch and ovf are 0; src_o = 0 and ovf_o = 0 while rst_ni is low.
Processing chain, per source n:
- Synchroniser: SYNC_STAGES flops; output s[n].
- Filter: f[n] = s[n] when the feature is off; otherwise filtered as described under Optional Feature.
- Normalise: a[n] = f[n] ^ pol_i[n].
Level mode:
- src_o[n] = a[n], combinational from the stage flops.
- Latency from raw change to src_o is SYNC_STAGES clocks (plus FILTER_CYCLES with the filter).
- consume_i[n] is ignored; latch[n] is held at 0.
Edge mode:
- prev[n] <= a[n] every cycle; a rising edge is a[n] & ~prev[n].
- The edge sets latch[n] on the next clock: raw-to-src_o latency is SYNC_STAGES+1.
- src_o[n] = latch[n].
- latch[n] clears on consume_i[n].
- Edge and consume_i[n] in the same cycle: the set wins and latch stays 1. This is a new event, not an overflow.
- Edge while latch[n]=1 and no consume that cycle: latch stays 1 and ovf[n] sets.
ovf rules:
- ovf[n] clears on ovf_clr_i[n].
- Set and clear in the same cycle: set wins.
Warm-up:
- A counter runs after reset deassertion for WARM = SYNC_STAGES+1 cycles (SYNC_STAGES+FILTER_CYCLES+1 with the filter).
- While the counter runs, prev tracks a, and latch and ovf cannot set. This prevents spurious edges from active-low sources whose normalised value is 1 out of reset.
- The counter saturates and stays idle until the next reset.
Config change (mode_i[n] or pol_i[n] differs from its registered copy):
- In that cycle, prev[n] <= a[n] using the new polarity.
- latch[n] clears; ovf[n] is kept.
- No edge is detected in that cycle.
Other rules:
- Sources are fully independent; there is no cross-source interaction.
- Asserting reset mid-operation clears everything immediately; pending latched edges are discarded.

Optional Feature:
Macro RVIC_SRC_FILTER_EN.
Defined:
- Each source gets a counter of width $clog2(FILTER_CYCLES+1), reset 0, and a filtered flop f[n], reset 0.
- While s[n] != f[n], the counter increments.
- When the counter reaches FILTER_CYCLES-1 with s[n] still != f[n], f[n] <= s[n] and the counter returns to 0. f[n] therefore follows a change that has been stable for FILTER_CYCLES cycles.
- Whenever s[n] == f[n], the counter resets to 0. Pulses shorter than FILTER_CYCLES are rejected.
Undefined:
- f[n] = s[n] directly; no counters are instantiated.
- Latencies and WARM exclude FILTER_CYCLES.

Test Plan:
1. Level mode, source 3, pol=0: raise irq_raw_i[3] at cycle 10 -> src_o[3]=1 from cycle 12 (SYNC_STAGES=2); drop at 20 -> 0 from 22; consume_i has no effect.
2. Edge mode, source 5: 1-cycle pulse at cycle 10 -> src_o[5]=1 from cycle 13 and held until consume_i[5] at 30 -> 0 at 31; ovf_o[5] stays 0.
3. Edge mode, source 7: second pulse arrives while latched -> ovf_o[7]=1 sticky; ovf_clr_i[7] clears it. Pulse whose edge coincides with consume_i[7] -> src_o[7] stays 1, ovf stays 0.
4. pol_i=all-ones, mode=edge, irq_raw_i=0 through reset release -> src_o=0 and ovf_o=0 for 50 cycles. Then pull line 0 high and low -> exactly one latch on the falling edge.
5. RVIC_SRC_FILTER_EN, FILTER_CYCLES=4, level mode: 3-cycle glitch -> src_o unchanged; 6-cycle pulse -> src_o high 6 cycles, starting 2+4 cycles after the rise.
6. Edge latched on sources 0 and 31, then rst_ni pulsed low mid-run -> src_o=0 and ovf_o=0 immediately. Toggling mode_i[0] clears latch[0] without a new event.
